// File: rtl/pitch_beep_pkg.sv
// pitch_beep_pkg: note-code constants, note frequency table, half-period
// derivation and the compiled-in song ROM shared by the pitch_beep slice.
package pitch_beep_pkg;

  localparam int unsigned NOTE_W     = 5;
  localparam int unsigned HALF_W     = 20;
  localparam int unsigned CNT_W      = 20;
  localparam int unsigned NOTE_CODES = 32;
  localparam int unsigned SONG_DEPTH = 32;

  // Note codes: 0 is rest, 1..7 low, 8..14 middle, 15..21 high do..si.
  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] DO_M      = 5'd8;
  localparam logic [NOTE_W-1:0] RE_M      = 5'd9;
  localparam logic [NOTE_W-1:0] MI_M      = 5'd10;
  localparam logic [NOTE_W-1:0] FA_M      = 5'd11;
  localparam logic [NOTE_W-1:0] SO_M      = 5'd12;
  localparam logic [NOTE_W-1:0] LA_M      = 5'd13;
  localparam logic [NOTE_W-1:0] NOTE_LAST = 5'd21;

  // Frequency in Hz per note code; codes 22..31 are silent.
  localparam int unsigned NOTE_HZ [NOTE_CODES] = '{
    0,
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988,
    1046, 1175, 1318, 1397, 1568, 1760, 1976,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0
  };

  // Song ROM, one note code per beat.
  localparam logic [NOTE_W-1:0] SONG [SONG_DEPTH] = '{
    DO_M, DO_M, SO_M, SO_M, LA_M, LA_M, SO_M, NOTE_REST,
    FA_M, FA_M, MI_M, MI_M, RE_M, RE_M, DO_M, NOTE_REST,
    SO_M, SO_M, FA_M, FA_M, MI_M, MI_M, RE_M, NOTE_REST,
    SO_M, SO_M, FA_M, FA_M, MI_M, MI_M, RE_M, NOTE_REST
  };

  typedef enum logic [1:0] {
    ST_REST = 2'd0,
    ST_GAP  = 2'd1,
    ST_TONE = 2'd2
  } state_e;

  // Half-period in clock cycles, truncated; 0 for silent codes.
  function automatic logic [HALF_W-1:0] calc_half_per(input int unsigned clk_hz,
                                                      input logic [NOTE_W-1:0] code);
    int unsigned hz;
    hz = NOTE_HZ[code];
    if (hz == 0) return '0;
    return HALF_W'(clk_hz / (2 * hz));
  endfunction

  // True for codes that produce a tone.
  function automatic logic note_is_tone(input logic [NOTE_W-1:0] code);
    return (code != NOTE_REST) && (code <= NOTE_LAST);
  endfunction

  // ROM lookup; indices past the stored song read as rest.
  function automatic logic [NOTE_W-1:0] song_at(input logic [9:0] idx);
    if (idx < 10'(SONG_DEPTH)) return SONG[idx[4:0]];
    return NOTE_REST;
  endfunction

endpackage

// File: rtl/pitch_beep_tone_gen.sv
// tone_gen: square-wave divider for the buzzer. A start pulse drives beep
// high and clears the divider; while run is held beep toggles every
// half_per cycles; otherwise beep is held low.
module tone_gen
  import pitch_beep_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [HALF_W-1:0] half_per,
  input  logic              tone_start,
  input  logic              tone_run,
  output logic              beep
);

  logic [HALF_W-1:0] div_cnt_reg;
  logic              beep_reg;

  // Divider and beep toggle; start wins over run, anything else silences.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt_reg <= '0;
      beep_reg    <= 1'b0;
    end else if (tone_start) begin
      div_cnt_reg <= '0;
      beep_reg    <= 1'b1;
    end else if (tone_run) begin
      if (div_cnt_reg == half_per - HALF_W'(1)) begin
        div_cnt_reg <= '0;
        beep_reg    <= ~beep_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + HALF_W'(1);
      end
    end else begin
      div_cnt_reg <= '0;
      beep_reg    <= 1'b0;
    end
  end

  assign beep = beep_reg;

endmodule

// File: rtl/pitch_beep.sv
// pitch_beep: maps the beat index pitch_num through the song ROM to a note,
// inserts a silent gap at each new beat, then drives the buzzer with a
// square wave at the note frequency.
// Build option: PITCH_BEEP_LOOP_EN wraps the index modulo SONG_LEN so the
// song repeats; without it, indices >= SONG_LEN play rest.
module pitch_beep
  import pitch_beep_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned GAP_CYC  = 500_000,
  parameter int unsigned SONG_LEN = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [8:0]        pitch_num,
  output logic              beep,
  output logic              tone_on,
  output logic [NOTE_W-1:0] note_code
);

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [9:0]       SONG_LEN_W = 10'(SONG_LEN);

  logic [8:0]        pitch_q_reg;
  logic [8:0]        pitch_p_reg;
  logic              first_reg;
  logic              chg_reg;
  logic [NOTE_W-1:0] note_code_reg;
  logic [NOTE_W-1:0] note_code_next;
  logic [HALF_W-1:0] half_per_reg;
  logic [HALF_W-1:0] half_tab [NOTE_CODES];
  logic [9:0]        song_idx;
  state_e            state_reg;
  logic [CNT_W-1:0]  gap_cnt_reg;
  logic              tone_on_reg;
  logic              gap_done;
  logic              tone_start;
  logic              tone_run;

  // Half-period constants, one per note code, fixed at elaboration.
  generate
    for (genvar gi = 0; gi < NOTE_CODES; gi++) begin : g_half
      assign half_tab[gi] = calc_half_per(CLK_HZ, NOTE_W'(gi));
    end
  endgenerate

`ifdef PITCH_BEEP_LOOP_EN
  assign song_idx       = {1'b0, pitch_q_reg} % SONG_LEN_W;
  assign note_code_next = song_at(song_idx);
`else
  assign song_idx       = {1'b0, pitch_q_reg};
  assign note_code_next = (song_idx >= SONG_LEN_W) ? NOTE_REST : song_at(song_idx);
`endif

  // Stage 1: capture the beat index and remember the previous one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pitch_q_reg <= '0;
      pitch_p_reg <= '0;
    end else begin
      pitch_q_reg <= pitch_num;
      pitch_p_reg <= pitch_q_reg;
    end
  end

  // Stage 2: note lookup plus a one-cycle change pulse (forced once after reset).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      note_code_reg <= NOTE_REST;
      half_per_reg  <= '0;
      chg_reg       <= 1'b0;
      first_reg     <= 1'b1;
    end else begin
      note_code_reg <= note_code_next;
      half_per_reg  <= half_tab[note_code_next];
      chg_reg       <= first_reg || (pitch_q_reg != pitch_p_reg);
      first_reg     <= 1'b0;
    end
  end

  assign gap_done   = (gap_cnt_reg == GAP_LAST);
  assign tone_start = (state_reg == ST_GAP) && !chg_reg && gap_done &&
                      note_is_tone(note_code_reg);
  assign tone_run   = (state_reg == ST_TONE) && !chg_reg;

  // Beat sequencer: a change always restarts the gap, the gap then opens a tone or rest.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= ST_REST;
      gap_cnt_reg <= '0;
      tone_on_reg <= 1'b0;
    end else if (chg_reg) begin
      state_reg   <= ST_GAP;
      gap_cnt_reg <= '0;
      tone_on_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_GAP: begin
          if (gap_done) begin
            gap_cnt_reg <= '0;
            if (note_is_tone(note_code_reg)) begin
              state_reg   <= ST_TONE;
              tone_on_reg <= 1'b1;
            end else begin
              state_reg   <= ST_REST;
              tone_on_reg <= 1'b0;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + CNT_W'(1);
          end
        end
        ST_TONE: begin
          tone_on_reg <= 1'b1;
        end
        default: begin
          state_reg   <= ST_REST;
          tone_on_reg <= 1'b0;
        end
      endcase
    end
  end

  tone_gen u_tone_gen (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .half_per   (half_per_reg),
    .tone_start (tone_start),
    .tone_run   (tone_run),
    .beep       (beep)
  );

  assign tone_on   = tone_on_reg;
  assign note_code = note_code_reg;

endmodule

// File: tb/tb_pitch_beep.sv
// tb_pitch_beep: random beat sequences against a beat-level reference model.
// Each beat pushes its expected output edges (cycle, value) into per-signal
// queues; a negedge monitor pops one entry for every edge the DUT shows.
`timescale 1ns/1ps
module tb_pitch_beep;

  localparam int CLK_HZ = 100_000;
  localparam int GAP    = 20;
  localparam int LEN    = 32;
  localparam int FREQ [22] = '{0, 262, 294, 330, 349, 392, 440, 494,
                               523, 587, 659, 698, 784, 880, 988,
                               1046, 1175, 1318, 1397, 1568, 1760, 1976};
  localparam int SONG8 [8] = '{8, 8, 12, 12, 13, 13, 12, 0};

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [8:0] pitch_num = '0;
  logic       beep;
  logic       tone_on;
  logic [4:0] note_code;

  pitch_beep #(.CLK_HZ(CLK_HZ), .GAP_CYC(GAP), .SONG_LEN(LEN)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pitch_num (pitch_num),
    .beep      (beep),
    .tone_on   (tone_on),
    .note_code (note_code)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int cur_code = 0;
  int prev_p = 0;
  int exp_cyc [3][$];
  int exp_val [3][$];
  int last_v [3] = '{0, 0, 0};
  int now_v [3];

  function automatic string sig_name(int i);
    case (i)
      0:       return "beep";
      1:       return "tone_on";
      default: return "note_code";
    endcase
  endfunction

  // Song rule: index wraps or reads as rest past the end; stimulus keeps idx < 8.
  function automatic int model_code(int p);
    int idx;
`ifdef PITCH_BEEP_LOOP_EN
    idx = p % LEN;
`else
    if (p >= LEN) return 0;
    idx = p;
`endif
    return SONG8[idx];
  endfunction

  function automatic int half_of(int code);
    return CLK_HZ / (2 * FREQ[code]);
  endfunction

  function automatic void expect_ev(int s, int c, int v);
    exp_cyc[s].push_back(c);
    exp_val[s].push_back(v);
  endfunction

  // Beat sampled at edge n; outputs silenced again at edge e.
  function automatic void push_beat(int n, int p, int e);
    int code, h, s, lv;
    code = model_code(p);
    if (code != cur_code) expect_ev(2, n + 1, code);
    cur_code = code;
    if (code != 0) begin
      h = half_of(code);
      s = n + 2 + GAP;
      if (s < e) begin
        expect_ev(1, s, 1);
        lv = 0;
        for (int t = s; t < e; t += h) begin
          lv = 1 - lv;
          expect_ev(0, t, lv);
        end
        if (lv == 1) expect_ev(0, e, 0);
        expect_ev(1, e, 0);
      end
    end
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic tick_to(int target);
    while (cyc < target) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic beat(int p, int d);
    int c;
    c = cyc;
    pitch_num = 9'(p);
    push_beat(c + 1, p, c + 1 + d + 2);
    prev_p = p;
    $display("beat pitch_num=%0d code=%0d hold=%0d at cycle %0d", p, model_code(p), d, c);
    tick_to(c + d);
  endtask

  task automatic release_reset(int d);
    int c;
    c = cyc;
    pitch_num = '0;
    sys_rst_n = 1'b1;
    cur_code  = 0;
    push_beat(c, 0, c + d + 2);
    prev_p = 0;
    $display("reset released at cycle %0d, hold=%0d", c, d);
    tick_to(c + d - 1);
  endtask

  // Edge counter.
  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
    end
  end

  // Monitor: each observed edge pops and checks one expected edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      now_v[0] = int'(beep);
      now_v[1] = int'(tone_on);
      now_v[2] = int'(note_code);
      for (int i = 0; i < 3; i++) begin
        if (now_v[i] != last_v[i]) begin
          n_cmp++;
          if (exp_cyc[i].size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected change to %0d at cycle %0d, none expected",
                     sig_name(i), now_v[i], cyc);
          end else begin
            int ec, ev;
            ec = exp_cyc[i].pop_front();
            ev = exp_val[i].pop_front();
            if (ec != cyc || ev != now_v[i]) begin
              n_bad++;
              $display("FAIL %s: got %0d at cycle %0d, want %0d at cycle %0d",
                       sig_name(i), now_v[i], cyc, ev, ec);
            end else begin
              $display("ok   %s -> %0d at cycle %0d", sig_name(i), now_v[i], cyc);
            end
          end
        end else if (exp_cyc[i].size() != 0 && exp_cyc[i][0] < cyc) begin
          int ec, ev;
          ec = exp_cyc[i].pop_front();
          ev = exp_val[i].pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL %s: stayed %0d, want %0d at cycle %0d", sig_name(i), now_v[i], ev, ec);
        end
        last_v[i] = now_v[i];
      end
    end
  end

  // Stimulus.
  initial begin
    int p, c, h, x;
    pitch_num = 9'($urandom_range(0, 511));
    tick_to(5);
    check("reset beep", int'(beep), 0);
    check("reset tone_on", int'(tone_on), 0);
    check("reset note_code", int'(note_code), 0);

    release_reset(300);
    beat(1, 150);
    beat(7, 100);
    beat(2, 60);
    beat(3, 200);
    beat(32, 100);
    beat(4, 15);
    beat(5, 180);
    for (int i = 0; i < 25; i++) begin
      do begin
        p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(32, 39));
      end while (p == prev_p);
      beat(p, int'($urandom_range(3, 350)));
    end

    // Reset asserted inside the first high half of a tone.
    p = (prev_p == 2) ? 3 : 2;
    c = cyc;
    pitch_num = 9'(p);
    h = half_of(12);
    x = c + 1 + 2 + GAP + h / 2;
    push_beat(c + 1, p, x);
    if (cur_code != 0) expect_ev(2, x, 0);
    cur_code = 0;
    prev_p = p;
    $display("beat pitch_num=%0d, reset planned at cycle %0d", p, x);
    tick_to(x);
    sys_rst_n = 1'b0;
    #1;
    check("async reset beep", int'(beep), 0);
    check("async reset tone_on", int'(tone_on), 0);
    check("async reset note_code", int'(note_code), 0);
    pitch_num = 9'($urandom_range(0, 511));
    tick_to(x + 4);
    release_reset(200);
    beat(7, 100);
    tick_to(cyc + 30);

    for (int i = 0; i < 3; i++) begin
      check({sig_name(i), " pending edges"}, exp_cyc[i].size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
